// File: rtl/mac_fetch_sequencer.sv
// Sequences int8 SIMD dot products: fetches input/filter word pairs over Wishbone, steps the MAC datapath once per pair.
// Latency 3*N+1 cycles on a zero-wait bus (+1 per wait state); holds the result until done_ready, accepts no command meanwhile.
module mac_fetch_sequencer #(
   parameter int LEN_W   = 16,
   parameter int TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [31:0]      start_input_addr,
   input  logic [31:0]      start_filter_addr,
   input  logic [LEN_W-1:0] start_len,
   output logic             done_valid,
   input  logic             done_ready,
   output logic [31:0]      done_sum,
   output logic             done_err,
   output logic             mac_clear,
   output logic             mac_en,
   output logic [31:0]      mac_a,
   output logic [31:0]      mac_b,
   input  logic [31:0]      mac_acc,
   output logic [29:0]      cfu_ram_adr,
   output logic [31:0]      cfu_ram_dat_mosi,
   output logic [3:0]       cfu_ram_sel,
   output logic             cfu_ram_cyc,
   output logic             cfu_ram_stb,
   output logic             cfu_ram_we,
   output logic [2:0]       cfu_ram_cti,
   output logic [1:0]       cfu_ram_bte,
   input  logic [31:0]      cfu_ram_dat_miso,
   input  logic             cfu_ram_ack,
   input  logic             cfu_ram_err
);

   typedef enum logic [2:0] {IDLE, FETCH_A, FETCH_B, MAC, RESP} state_t;

   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

   state_t           state;
   logic [29:0]      a_ptr;
   logic [29:0]      b_ptr;
   logic [LEN_W-1:0] remaining;
   logic [31:0]      a_reg;
   logic [31:0]      b_reg;
   logic [15:0]      tmo_cnt;
   logic             err_q;
   logic             fetching;
   logic             abort;
   logic             unused_addr_lsbs;

   assign fetching = (state == FETCH_A) || (state == FETCH_B);
   // err beats a simultaneous ack; timeout fires on the TIMEOUT-th silent cycle
   assign abort    = fetching && (cfu_ram_err || (!cfu_ram_ack && tmo_cnt == TMO_LAST));

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         a_ptr     <= '0;
         b_ptr     <= '0;
         remaining <= '0;
         a_reg     <= '0;
         b_reg     <= '0;
         tmo_cnt   <= '0;
         err_q     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start_valid) begin
                  a_ptr     <= start_input_addr[31:2];
                  b_ptr     <= start_filter_addr[31:2];
                  remaining <= start_len;
                  err_q     <= 1'b0;
                  tmo_cnt   <= '0;
                  state     <= (start_len == '0) ? RESP : FETCH_A;
               end
            end
            FETCH_A, FETCH_B: begin
               if (abort) begin
                  err_q <= 1'b1;
                  state <= RESP;
               end else if (cfu_ram_ack) begin
                  tmo_cnt <= '0;
                  if (state == FETCH_A) begin
                     a_reg <= cfu_ram_dat_miso;
                     state <= FETCH_B;
                  end else begin
                     b_reg <= cfu_ram_dat_miso;
                     state <= MAC;
                  end
               end else begin
                  tmo_cnt <= tmo_cnt + 16'd1;
               end
            end
            MAC: begin
               a_ptr     <= a_ptr + 30'd1;
               b_ptr     <= b_ptr + 30'd1;
               remaining <= remaining - LEN_W'(1);
               tmo_cnt   <= '0;
               state     <= (remaining == LEN_W'(1)) ? RESP : FETCH_A;
            end
            RESP: begin
               if (done_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign start_ready      = (state == IDLE);
   assign mac_clear        = (state == IDLE) && start_valid;
   assign mac_en           = (state == MAC);
   assign mac_a            = a_reg;
   assign mac_b            = b_reg;
   assign done_valid       = (state == RESP);
   assign done_sum         = mac_acc;
   assign done_err         = err_q;

   assign cfu_ram_cyc      = fetching;
   assign cfu_ram_stb      = fetching;
   assign cfu_ram_adr      = (state == FETCH_B) ? b_ptr : a_ptr;
   assign cfu_ram_dat_mosi = 32'd0;
   assign cfu_ram_sel      = 4'b1111;
   assign cfu_ram_we       = 1'b0;
   assign cfu_ram_cti      = 3'd0;
   assign cfu_ram_bte      = 2'd0;

   assign unused_addr_lsbs = ^{start_input_addr[1:0], start_filter_addr[1:0]};

endmodule

// File: tb/tb_mac_fetch_sequencer.sv
// Scoreboarded bench for mac_fetch_sequencer: bus, MAC and result responses checked against queued expectations.
module tb_mac_fetch_sequencer;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        start_valid;
   logic        start_ready;
   logic [31:0] start_input_addr;
   logic [31:0] start_filter_addr;
   logic [15:0] start_len;
   logic        done_valid;
   logic        done_ready;
   logic [31:0] done_sum;
   logic        done_err;
   logic        mac_clear;
   logic        mac_en;
   logic [31:0] mac_a;
   logic [31:0] mac_b;
   logic [31:0] mac_acc = 32'd0;
   logic [29:0] cfu_ram_adr;
   logic [31:0] cfu_ram_dat_mosi;
   logic [3:0]  cfu_ram_sel;
   logic        cfu_ram_cyc;
   logic        cfu_ram_stb;
   logic        cfu_ram_we;
   logic [2:0]  cfu_ram_cti;
   logic [1:0]  cfu_ram_bte;
   logic [31:0] cfu_ram_dat_miso = 32'd0;
   logic        cfu_ram_ack = 1'b0;
   logic        cfu_ram_err = 1'b0;

   mac_fetch_sequencer #(.LEN_W(16), .TIMEOUT(255)) dut (
      .clk(clk), .reset(reset),
      .start_valid(start_valid), .start_ready(start_ready),
      .start_input_addr(start_input_addr), .start_filter_addr(start_filter_addr), .start_len(start_len),
      .done_valid(done_valid), .done_ready(done_ready), .done_sum(done_sum), .done_err(done_err),
      .mac_clear(mac_clear), .mac_en(mac_en), .mac_a(mac_a), .mac_b(mac_b), .mac_acc(mac_acc),
      .cfu_ram_adr(cfu_ram_adr), .cfu_ram_dat_mosi(cfu_ram_dat_mosi), .cfu_ram_sel(cfu_ram_sel),
      .cfu_ram_cyc(cfu_ram_cyc), .cfu_ram_stb(cfu_ram_stb), .cfu_ram_we(cfu_ram_we),
      .cfu_ram_cti(cfu_ram_cti), .cfu_ram_bte(cfu_ram_bte), .cfu_ram_dat_miso(cfu_ram_dat_miso),
      .cfu_ram_ack(cfu_ram_ack), .cfu_ram_err(cfu_ram_err)
   );

   typedef struct packed {
      logic [31:0] sum;
      logic        err;
      logic [31:0] lat;
   } done_t;

   int          checks = 0;
   int          errors = 0;
   int          cyc_n  = 0;
   logic [29:0] exp_adr[$];
   logic [63:0] exp_mac[$];
   done_t       exp_done[$];
   logic [31:0] mem[0:255];
   logic [31:0] vec_a[0:3];
   logic [31:0] vec_b[0:3];

   int wait_n     = 0;
   int err_idx    = -1;
   bit no_ack     = 1'b0;
   bit inject_ack = 1'b0;
   int acc_idx    = 0;
   int wcnt       = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: unexpected event or expired wait (got event, required none)", name);
   endtask

   function automatic logic [31:0] dot(input logic [31:0] a, input logic [31:0] b);
      int s = 0;
      for (int i = 0; i < 4; i++)
         s += int'($signed(a[8*i +: 8])) * int'($signed(b[8*i +: 8]));
      return 32'(s);
   endfunction

   always @(posedge clk) cyc_n++;

   // Wishbone slave: wait_n wait states per access, optional error on access number err_idx
   always @(negedge clk) begin
      if (cfu_ram_ack || cfu_ram_err) begin
         cfu_ram_ack = 1'b0;
         cfu_ram_err = 1'b0;
         acc_idx++;
         wcnt = 0;
      end
      if (inject_ack) begin
         cfu_ram_ack = 1'b1;
      end else if (cfu_ram_stb && !no_ack) begin
         if (wcnt >= wait_n) begin
            if (exp_adr.size() == 0) fail("bus_adr_extra");
            else chk("bus_adr", 32'(cfu_ram_adr), 32'(exp_adr.pop_front()));
            cfu_ram_ack = 1'b1;
            if (acc_idx == err_idx) cfu_ram_err = 1'b1;
            else cfu_ram_dat_miso = mem[cfu_ram_adr[7:0]];
         end else begin
            wcnt++;
         end
      end else if (!cfu_ram_stb) begin
         wcnt = 0;
      end
   end

   // MAC datapath model plus monitors for mac_en pulses and results
   int   acc_cyc  = 0;
   int   rise_cyc = 0;
   bit   dv_q     = 1'b0;
   always @(negedge clk) begin
      logic [63:0] m;
      done_t       d;
      if (start_valid && start_ready) acc_cyc = cyc_n;
      if (mac_clear) mac_acc = 32'd0;
      if (mac_en) begin
         if (exp_mac.size() == 0) fail("mac_en_extra");
         else begin
            m = exp_mac.pop_front();
            chk("mac_a", mac_a, m[63:32]);
            chk("mac_b", mac_b, m[31:0]);
         end
         mac_acc = mac_acc + dot(mac_a, mac_b);
      end
      if (done_valid && !dv_q) rise_cyc = cyc_n;
      dv_q = done_valid;
      if (done_valid && done_ready) begin
         if (exp_done.size() == 0) fail("done_extra");
         else begin
            d = exp_done.pop_front();
            chk("done_sum", done_sum, d.sum);
            chk("done_err", 32'(done_err), 32'(d.err));
            chk("done_latency", 32'(rise_cyc - acc_cyc), d.lat);
            chk("done_bus_idle", {30'd0, cfu_ram_cyc, cfu_ram_stb}, 32'd0);
         end
      end
   end

   task automatic send(input logic [31:0] ia, input logic [31:0] fa, input logic [15:0] n);
      bit got = 1'b0;
      @(posedge clk); #1;
      start_input_addr  = ia;
      start_filter_addr = fa;
      start_len         = n;
      start_valid       = 1'b1;
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge clk);
         if (start_ready) got = 1'b1;
      end
      if (!got) fail("accept_wait");
      else chk("mac_clear_on_accept", 32'(mac_clear), 32'd1);
      @(posedge clk); #1;
      start_valid = 1'b0;
   endtask

   task automatic drain(input int budget);
      int i = 0;
      while (exp_done.size() != 0 && i < budget) begin
         @(posedge clk);
         i++;
      end
      if (exp_done.size() != 0) fail("done_wait");
      @(posedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      reset = 1'b0; start_valid = 1'b0; start_input_addr = '0; start_filter_addr = '0;
      start_len = '0; done_ready = 1'b1;
      vec_a[0] = 32'h01020304; vec_b[0] = 32'h01010101;
      vec_a[1] = 32'hFF010203; vec_b[1] = 32'h02020202;
      vec_a[2] = 32'h7F7F7F7F; vec_b[2] = 32'h01000000;
      vec_a[3] = 32'h80808080; vec_b[3] = 32'hFFFFFFFF;
      for (int i = 0; i < 256; i++) mem[i] = 32'd0;
      for (int k = 0; k < 4; k++) begin
         mem[8'h40 + k] = vec_a[k];
         mem[8'h80 + k] = vec_b[k];
      end
      mem[8'hFF] = 32'h02020202;
      mem[8'h00] = 32'h03030303;

      // reset and idle outputs
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      chk("rst_start_ready", 32'(start_ready), 32'd1);
      chk("rst_cyc", 32'(cfu_ram_cyc), 32'd0);
      chk("rst_stb", 32'(cfu_ram_stb), 32'd0);
      chk("rst_done_valid", 32'(done_valid), 32'd0);
      chk("rst_mac_en", 32'(mac_en), 32'd0);
      chk("rst_mac_clear", 32'(mac_clear), 32'd0);
      chk("rst_sel", 32'(cfu_ram_sel), 32'hF);
      chk("rst_we", 32'(cfu_ram_we), 32'd0);

      // single pair, zero-wait: 1+2+3+4 = 10
      exp_adr.push_back(30'h40); exp_adr.push_back(30'h80);
      exp_mac.push_back({32'h01020304, 32'h01010101});
      exp_done.push_back('{32'd10, 1'b0, 32'd4});
      send(32'h100, 32'h200, 16'd1);
      drain(100);

      // four pairs, one wait state per access: 10+10+127+512 = 659, 3*4+1+8 = 21
      wait_n = 1;
      for (int k = 0; k < 4; k++) begin
         exp_adr.push_back(30'h40 + 30'(k)); exp_adr.push_back(30'h80 + 30'(k));
         exp_mac.push_back({vec_a[k], vec_b[k]});
      end
      exp_done.push_back('{32'd659, 1'b0, 32'd21});
      send(32'h100, 32'h202, 16'd4);
      drain(200);
      wait_n = 0;

      // zero length: cleared accumulator, result next cycle
      exp_done.push_back('{32'd0, 1'b0, 32'd1});
      send(32'h300, 32'h400, 16'd0);
      drain(50);

      // error together with ack on the second pair's filter fetch
      err_idx = acc_idx + 3;
      exp_adr.push_back(30'h40); exp_adr.push_back(30'h80);
      exp_adr.push_back(30'h41); exp_adr.push_back(30'h81);
      exp_mac.push_back({32'h01020304, 32'h01010101});
      exp_done.push_back('{32'd10, 1'b1, 32'd6});
      send(32'h100, 32'h200, 16'd3);
      drain(100);
      err_idx = -1;

      // silent bus: abort after 255 cycles without a response
      no_ack = 1'b1;
      exp_done.push_back('{32'd0, 1'b1, 32'd256});
      send(32'h100, 32'h200, 16'd2);
      drain(400);
      no_ack = 1'b0;

      // backpressure: result held, new command refused
      done_ready = 1'b0;
      exp_adr.push_back(30'h40); exp_adr.push_back(30'h80);
      exp_mac.push_back({32'h01020304, 32'h01010101});
      exp_done.push_back('{32'd10, 1'b0, 32'd4});
      send(32'h100, 32'h200, 16'd1);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (done_valid) seen = 1'b1;
      end
      if (!seen) fail("bp_done_wait");
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         start_input_addr = 32'h500; start_filter_addr = 32'h600; start_len = 16'd1;
         start_valid = 1'b1;
         @(negedge clk);
         chk("bp_done_valid", 32'(done_valid), 32'd1);
         chk("bp_done_sum", done_sum, 32'd10);
         chk("bp_start_ready", 32'(start_ready), 32'd0);
      end
      @(posedge clk); #1;
      start_valid = 1'b0;
      done_ready  = 1'b1;
      drain(50);

      // reset during the filter fetch; a late ack must be ignored
      wait_n = 3;
      exp_adr.push_back(30'h40);
      send(32'h100, 32'h200, 16'd1);
      seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk);
         if (cfu_ram_stb && cfu_ram_adr == 30'h80) seen = 1'b1;
      end
      if (!seen) fail("rst_fetch_b_wait");
      @(posedge clk); #1 reset = 1'b0;
      @(posedge clk); #1 reset = 1'b1;
      chk("midrst_cyc", 32'(cfu_ram_cyc), 32'd0);
      chk("midrst_stb", 32'(cfu_ram_stb), 32'd0);
      chk("midrst_start_ready", 32'(start_ready), 32'd1);
      @(posedge clk); #1 inject_ack = 1'b1;
      @(posedge clk); #1 inject_ack = 1'b0;
      @(posedge clk); #1;
      chk("late_ack_start_ready", 32'(start_ready), 32'd1);
      chk("late_ack_cyc", 32'(cfu_ram_cyc), 32'd0);
      chk("late_ack_done_valid", 32'(done_valid), 32'd0);
      wait_n = 0;

      // pointer wrap at the top of the word space: 8 + 24 = 32
      exp_adr.push_back(30'h3FFFFFFF); exp_adr.push_back(30'h80);
      exp_adr.push_back(30'h0);        exp_adr.push_back(30'h81);
      exp_mac.push_back({32'h02020202, 32'h01010101});
      exp_mac.push_back({32'h03030303, 32'h02020202});
      exp_done.push_back('{32'd32, 1'b0, 32'd7});
      send(32'hFFFFFFFC, 32'h200, 16'd2);
      drain(100);

      repeat (3) @(posedge clk);
      chk("left_adr", 32'(exp_adr.size()), 32'd0);
      chk("left_mac", 32'(exp_mac.size()), 32'd0);
      chk("left_done", 32'(exp_done.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
